mult_datapath: RTL

MULT_DATAPATH -- requirements
Module: mult_datapath

---
 rtl/mult_datapath.sv | 98 +++++++++
 1 files changed

// File: rtl/mult_datapath.sv
// Shift-and-normalise multiplier datapath: two operand registers, a saturating
// shift counter and a right-shifting output register, all driven by an external sequencer.
module mult_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        rst5,
    input  logic        loadA,
    input  logic        loadB,
    input  logic        shlA,
    input  logic        shlB,
    input  logic        cntU,
    input  logic        cntD,
    input  logic        loadOut,
    input  logic        shrOut,
    output logic        DoneA,
    output logic        DoneB,
    output logic        downDone,
    output logic [31:0] result
);

    localparam int unsigned OP_W   = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned HALF_W = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;

    logic [OP_W-1:0]  rega_q, rega_d;
    logic [OP_W-1:0]  regb_q, regb_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [OUT_W-1:0] out_q,  out_d;
    logic [OP_W-1:0]  prod_c;

    // Only the top byte of each normalised operand feeds the multiplier.
    assign prod_c = OP_W'(rega_q[OP_W-1 -: HALF_W]) * OP_W'(regb_q[OP_W-1 -: HALF_W]);

    always_comb begin
        rega_d = rega_q;
        regb_d = regb_q;
        cnt_d  = cnt_q;
        out_d  = out_q;

        if (loadA) begin
            rega_d = A;
        end else if (shlA) begin
            rega_d = {rega_q[OP_W-2:0], 1'b0};
        end

        if (loadB) begin
            regb_d = B;
        end else if (shlB) begin
            regb_d = {regb_q[OP_W-2:0], 1'b0};
        end

        // Counter saturates at both ends rather than wrapping.
        if (rst5) begin
            cnt_d = '0;
        end else if (cntU) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (cntD) begin
            if (cnt_q != CNT_MIN) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (loadOut) begin
            out_d = {prod_c, 16'h0000};
        end else if (shrOut) begin
            out_d = {1'b0, out_q[OUT_W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rega_q <= '0;
            regb_q <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
        end else begin
            rega_q <= rega_d;
            regb_q <= regb_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    // A zero operand counts as normalised so the sequencer never shifts forever.
    assign DoneA    = rega_q[OP_W-1] | (rega_q == '0);
    assign DoneB    = regb_q[OP_W-1] | (regb_q == '0);
    assign downDone = (cnt_q == '0);
    assign result   = out_q;

endmodule
